// File: rtl/osc_fll_pkg.sv
// Shared types and constants for the oscillator frequency-lock controller.
// Covers the FSM state encoding and the ctrl code range.
`timescale 1ps/1ps
package osc_fll_pkg;

    localparam int unsigned CTRL_W = 2;
    localparam logic [CTRL_W-1:0] CTRL_MIN = 2'd0;
    localparam logic [CTRL_W-1:0] CTRL_MAX = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_UPDATE
    } fll_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_fll_ctrl_if.sv
// Control/status bundle between the frequency-lock controller and its user/oscillator.
// master drives enable, oscillator phase and target; slave returns ctrl and measurement status.
`timescale 1ps/1ps
interface osc_fll_ctrl_if
    import osc_fll_pkg::*;
#(
    parameter int unsigned CNT_W = 10
) ();
    logic              en;
    logic              osc_a;
    logic [CNT_W-1:0]  target_count;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  count_out;
    logic              count_valid;
    logic              locked;

    modport master (
        output en, osc_a, target_count,
        input  ctrl, count_out, count_valid, locked
    );

    modport slave (
        input  en, osc_a, target_count,
        output ctrl, count_out, count_valid, locked
    );
endinterface

// File: rtl/osc_fll_ctrl_edge_sync.sv
// Brings the free-running oscillator phase into clk and emits one pulse per rising edge.
// Pulse lags the input by 2-3 clk; pulses closer than 2 clk apart are lost.
`timescale 1ps/1ps
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_pulse = s2_q & ~s3_q;
endmodule

// File: rtl/osc_fll_ctrl.sv
// Frequency-lock loop: counts oscillator edges per window and steps ctrl toward the target.
// Higher ctrl slows the oscillator, so a high count steps ctrl up.
`timescale 1ps/1ps
module osc_fll_ctrl
    import osc_fll_pkg::*;
#(
    parameter int unsigned       WINDOW     = 256,
    parameter int unsigned       SETTLE_CYC = 16,
    parameter int unsigned       CNT_W      = 10,
    parameter int unsigned       TOL        = 1,
    parameter int unsigned       LOCK_N     = 4,
    parameter logic [CTRL_W-1:0] CTRL_INIT  = 2'd0
) (
    input logic           clk,
    input logic           rst,
    osc_fll_ctrl_if.slave bus
);
    localparam int unsigned      TMR_W    = $clog2(max_u(WINDOW, SETTLE_CYC));
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W:0]   CNT_SAT  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);

    fll_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  count_out_q, count_out_d;
    logic              count_valid_q, count_valid_d;
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    logic              osc_rise;
    logic [CNT_W:0]    cnt_sum, band_hi_raw, band_hi, band_lo;
    logic [CNT_W-1:0]  cnt_inc;
    logic [3:0]        lock_inc;
    logic              too_fast, too_slow;

    osc_edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (bus.osc_a),
        .rise_pulse (osc_rise)
    );

    // Band limits clamp to [0, 2^CNT_W-1] instead of wrapping.
    always_comb begin
        cnt_sum     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, osc_rise};
        cnt_inc     = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        lock_inc    = (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
        band_hi_raw = {1'b0, tgt_q} + TOL_X;
        band_hi     = (band_hi_raw > CNT_SAT) ? CNT_SAT : band_hi_raw;
        band_lo     = ({1'b0, tgt_q} >= TOL_X) ? ({1'b0, tgt_q} - TOL_X) : '0;
        too_fast    = {1'b0, count_out_q} > band_hi;
        too_slow    = {1'b0, count_out_q} < band_lo;
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        cnt_d         = cnt_q;
        tgt_d         = tgt_q;
        ctrl_d        = ctrl_q;
        count_out_d   = count_out_q;
        count_valid_d = 1'b0;
        lock_cnt_d    = lock_cnt_q;
        locked_d      = locked_q;

        case (state_q)
            ST_IDLE: begin
                locked_d   = 1'b0;
                lock_cnt_d = 4'd0;
                state_d    = ST_SETTLE;
                tmr_d      = SET_LOAD;
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = ST_MEASURE;
                    tmr_d   = WIN_LOAD;
                    cnt_d   = '0;
                    tgt_d   = bus.target_count;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_MEASURE: begin
                cnt_d = cnt_inc;
                if (tmr_q == '0) begin
                    state_d       = ST_UPDATE;
                    count_out_d   = cnt_inc;
                    count_valid_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_UPDATE: begin
                state_d = ST_MEASURE;
                tmr_d   = WIN_LOAD;
                cnt_d   = '0;
                tgt_d   = bus.target_count;
                if (too_fast || too_slow) begin
                    lock_cnt_d = 4'd0;
                    locked_d   = 1'b0;
                    if (too_fast && ctrl_q != CTRL_MAX) begin
                        ctrl_d  = ctrl_q + 1'b1;
                        state_d = ST_SETTLE;
                        tmr_d   = SET_LOAD;
                    end else if (too_slow && ctrl_q != CTRL_MIN) begin
                        ctrl_d  = ctrl_q - 1'b1;
                        state_d = ST_SETTLE;
                        tmr_d   = SET_LOAD;
                    end
                end else begin
                    lock_cnt_d = lock_inc;
                    locked_d   = (32'(lock_inc) >= LOCK_N);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping enable abandons the window without reporting it.
        if (!bus.en) begin
            state_d       = ST_IDLE;
            ctrl_d        = ctrl_q;
            count_out_d   = count_out_q;
            count_valid_d = 1'b0;
            lock_cnt_d    = 4'd0;
            locked_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            cnt_q         <= '0;
            tgt_q         <= '0;
            ctrl_q        <= CTRL_INIT;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            lock_cnt_q    <= 4'd0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            ctrl_q        <= ctrl_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.ctrl        = ctrl_q;
    assign bus.count_out   = count_out_q;
    assign bus.count_valid = count_valid_q;
    assign bus.locked      = locked_q;
endmodule
